// File: rtl/obj_shadow_table.sv
// Double-buffered background/object table: CPU writes go to a shadow copy that is
// copied into the active (renderer-visible) table at vsync. Option macro: AUTO_COMMIT_EN.
module obj_shadow_table #(
  parameter int NUM_OBJ = 20,
  parameter int FCNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chipselect_i,
  input  logic                   write_i,
  input  logic                   read_i,
  input  logic [4:0]             address_i,
  input  logic [31:0]            writedata_i,
  output logic [31:0]            readdata_o,
  output logic                   waitrequest_o,
  input  logic                   vga_vs_n_i,
  output logic [23:0]            bg_rgb_o,
  output logic [NUM_OBJ*32-1:0]  obj_table_o,
  output logic                   irq_o
);

  localparam int         IDX_W  = $clog2(NUM_OBJ + 1);
  localparam logic [4:0] CTRL_A = 5'(NUM_OBJ + 1);
  localparam logic [4:0] STAT_A = 5'(NUM_OBJ + 2);
  localparam logic [23:0] BG_RST = 24'h000020;
`ifdef AUTO_COMMIT_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  function automatic logic [31:0] entry_rst(input int i);
    case (i)
      0:       entry_rst = 32'h0C80F002;
      1:       entry_rst = 32'h32009606;
      2:       entry_rst = 32'h32015E06;
      default: entry_rst = 32'h0;
    endcase
  endfunction

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      pending_q, pending_d;
  logic                      irq_q, irq_d;
  logic [FCNT_W-1:0]         fcnt_q, fcnt_d;
  logic [31:0]               readdata_q, readdata_d;
  logic                      vs_q;
  logic [23:0]               sh_bg_q, act_bg_q;
  logic [NUM_OBJ-1:0][31:0]  sh_obj_q, act_obj_q;

  logic vs_fall, acc, wr_acc, rd_acc, ctrl_wr, busy;
  logic [31:0] status;

  assign vs_fall = vs_q & ~vga_vs_n_i;
  assign acc     = chipselect_i & ~waitrequest_o;
  assign wr_acc  = acc & write_i;
  assign rd_acc  = acc & read_i;
  assign ctrl_wr = wr_acc & (address_i == CTRL_A);
  assign busy    = (state_q != IDLE);
  assign status  = 32'({fcnt_q, 13'b0, irq_q, pending_q, busy});

  assign waitrequest_o = (state_q == COPY);
  assign readdata_o    = readdata_q;
  assign irq_o         = irq_q;
  assign bg_rgb_o      = act_bg_q;
  assign obj_table_o   = act_obj_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (vs_fall && pending_q) begin
        state_d = COPY;
        idx_d   = '0;
      end
      COPY: begin
        if (idx_q == IDX_W'(NUM_OBJ)) state_d = DONE;
        else                          idx_d   = idx_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pending is only sampled in IDLE, so a request landing on the vs_fall edge waits a frame
  always_comb begin
    pending_d = pending_q;
    irq_d     = irq_q;
    if (state_q == DONE) pending_d = AUTO;
    if (!AUTO && ctrl_wr && writedata_i[0]) pending_d = 1'b1;
    if (ctrl_wr && writedata_i[1]) irq_d = 1'b0;
    if (state_q == DONE) irq_d = 1'b1;
    fcnt_d = fcnt_q + FCNT_W'(vs_fall);
  end

  always_comb begin
    readdata_d = readdata_q;
    if (rd_acc) begin
      readdata_d = '0;
      if (address_i == 5'd0)    readdata_d = {8'h0, sh_bg_q};
      if (address_i == STAT_A)  readdata_d = status;
      for (int i = 0; i < NUM_OBJ; i++)
        if (address_i == 5'(i + 1)) readdata_d = sh_obj_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pending_q  <= AUTO;
      irq_q      <= 1'b0;
      fcnt_q     <= '0;
      readdata_q <= '0;
      vs_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
      fcnt_q     <= fcnt_d;
      readdata_q <= readdata_d;
      vs_q       <= vga_vs_n_i;
    end
  end

  // shadow is frozen during COPY because bus writes are stalled by waitrequest
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_bg_q  <= BG_RST;
      act_bg_q <= BG_RST;
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh_obj_q[i]  <= entry_rst(i);
        act_obj_q[i] <= entry_rst(i);
      end
    end else begin
      if (wr_acc && address_i == 5'd0) sh_bg_q <= writedata_i[23:0];
      for (int i = 0; i < NUM_OBJ; i++)
        if (wr_acc && address_i == 5'(i + 1)) sh_obj_q[i] <= writedata_i;
      if (state_q == COPY) begin
        if (idx_q == '0) act_bg_q <= sh_bg_q;
        for (int i = 0; i < NUM_OBJ; i++)
          if (idx_q == IDX_W'(i + 1)) act_obj_q[i] <= sh_obj_q[i];
      end
    end
  end

endmodule

// File: tb/tb_obj_shadow_table.sv
// Directed bench for obj_shadow_table (default build, NUM_OBJ = 20).
module tb_obj_shadow_table;
  localparam int NUM_OBJ = 20;
  localparam logic [4:0] CTRL_A = 5'd21;
  localparam logic [4:0] STAT_A = 5'd22;

  logic clk, reset, chipselect, write, read, vs_n, waitrequest, irq;
  logic [4:0]  address;
  logic [31:0] writedata, readdata, rd;
  logic [23:0] bg_rgb;
  logic [NUM_OBJ*32-1:0] obj_table;
  int passed = 0, total = 0, exp_fc = 0, n;

  obj_shadow_table #(.NUM_OBJ(NUM_OBJ), .FCNT_W(16)) dut (
    .clk(clk), .reset(reset), .chipselect_i(chipselect), .write_i(write), .read_i(read),
    .address_i(address), .writedata_i(writedata), .readdata_o(readdata),
    .waitrequest_o(waitrequest), .vga_vs_n_i(vs_n), .bg_rgb_o(bg_rgb),
    .obj_table_o(obj_table), .irq_o(irq));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string tag);
    n = 0;
    while (waitrequest && n < 100) begin tick(); n++; end
    check(tag, 32'(n < 100), 32'd1);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    wait_ready("wr_bound");
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    wait_ready("rd_bound");
    tick();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic vs_pulse();
    vs_n = 1'b0; tick(); exp_fc++;
    vs_n = 1'b1; tick();
  endtask

  initial begin
    reset = 1'b1; chipselect = 0; write = 0; read = 0; address = 0; writedata = 0; vs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    check("rst_entry0", obj_table[0*32+:32], 32'h0C80F002);
    check("rst_entry1", obj_table[1*32+:32], 32'h32009606);
    check("rst_entry2", obj_table[2*32+:32], 32'h32015E06);
    check("rst_bg", 32'(bg_rgb), 32'h000020);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_wait", 32'(waitrequest), 32'd0);
    check("rst_rdata", readdata, 32'h0);

    // shadow write without commit
    bus_write(5'd1, 32'h0640C802);
    vs_pulse(); vs_pulse();
    check("nocommit_entry0", obj_table[0*32+:32], 32'h0C80F002);
    bus_read(5'd1, rd);  check("shadow_rd1", rd, 32'h0640C802);
    bus_read(STAT_A, rd); check("status_fc2", rd, 32'h0002_0000);
    bus_read(5'd31, rd); check("undef_rd", rd, 32'h0);

    // explicit commit: copy window length
    bus_write(5'd0, 32'h00ABCDEF);
    bus_write(CTRL_A, 32'h1);
    bus_read(STAT_A, rd); check("status_pending", rd, 32'h0002_0002);
    vs_n = 1'b0; tick(); exp_fc++;
    n = 0;
    while (waitrequest && n < 100) begin n++; tick(); end
    vs_n = 1'b1;
    check("copy_cycles", 32'(n), 32'd21);
    tick();
    check("commit_entry0", obj_table[0*32+:32], 32'h0640C802);
    check("commit_bg", 32'(bg_rgb), 32'h00ABCDEF);
    check("commit_irq", 32'(irq), 32'd1);
    bus_read(STAT_A, rd); check("status_done", rd, 32'h0003_0004);

    // irq clear
    bus_write(CTRL_A, 32'h2);
    check("irq_clear", 32'(irq), 32'd0);

    // request on the vs_fall edge waits one frame
    vs_n = 1'b0;
    bus_write(CTRL_A, 32'h1);
    exp_fc++;
    check("sameedge_nocopy", 32'(waitrequest), 32'd0);
    vs_n = 1'b1; tick();
    bus_read(STAT_A, rd); check("sameedge_pending", rd, {16'(exp_fc), 16'h0002});

    // write held during COPY
    bus_write(5'd1, 32'h11111102);
    vs_n = 1'b0; tick(); exp_fc++; vs_n = 1'b1;
    check("copy_busy", 32'(waitrequest), 32'd1);
    bus_write(5'd3, 32'hDEADBEE0);
    check("held_entry0", obj_table[0*32+:32], 32'h11111102);
    check("held_entry2_active", obj_table[2*32+:32], 32'h32015E06);
    bus_read(5'd3, rd); check("held_shadow", rd, 32'hDEADBEE0);
    vs_pulse();
    check("norq_entry2", obj_table[2*32+:32], 32'h32015E06);

    // clear in DONE cycle loses to set
    bus_write(CTRL_A, 32'h2);
    check("irq_clear2", 32'(irq), 32'd0);
    bus_write(CTRL_A, 32'h1);
    vs_n = 1'b0; tick(); exp_fc++; vs_n = 1'b1;
    bus_write(CTRL_A, 32'h2);
    tick();
    check("done_clear_irq", 32'(irq), 32'd1);
    check("commit2_entry2", obj_table[2*32+:32], 32'hDEADBEE0);
    bus_read(STAT_A, rd); check("status_fc", rd, {16'(exp_fc), 16'h0004});

    // reset mid-COPY at idx 5
    bus_write(CTRL_A, 32'h2);
    bus_write(5'd0, 32'h00123456);
    bus_write(5'd1, 32'h22222202);
    bus_write(CTRL_A, 32'h1);
    vs_n = 1'b0; tick(); vs_n = 1'b1;
    repeat (5) tick();
    check("midcopy_busy", 32'(waitrequest), 32'd1);
    check("midcopy_bg", 32'(bg_rgb), 32'h00123456);
    reset = 1'b1; #1;
    check("abort_bg", 32'(bg_rgb), 32'h000020);
    check("abort_entry0", obj_table[0*32+:32], 32'h0C80F002);
    check("abort_entry2", obj_table[2*32+:32], 32'h32015E06);
    check("abort_irq", 32'(irq), 32'd0);
    check("abort_wait", 32'(waitrequest), 32'd0);
    check("abort_rdata", readdata, 32'h0);
    tick(); reset = 1'b0; exp_fc = 0;
    bus_read(STAT_A, rd); check("abort_status", rd, 32'h0);
    vs_pulse(); tick();
    check("abort_noirq", 32'(irq), 32'd0);
    bus_read(5'd1, rd); check("abort_shadow1", rd, 32'h0C80F002);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
